// File: rtl/tdc_hit_readout_arbiter.sv
// Multi-channel TDC hit collector: timestamps captured hits with a free-running
// coarse counter and serialises them onto one valid/ready port, round-robin.
module tdc_hit_readout_arbiter #(
  parameter int unsigned NCH      = 8,
  parameter int unsigned CH_W     = 3,
  parameter int unsigned FINE_W   = 4,
  parameter int unsigned COARSE_W = 16
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              enable,
  input  logic [NCH-1:0]                    hit_valid,
  input  logic [NCH*FINE_W-1:0]             hit_fine,
  output logic                              out_valid,
  input  logic                              out_ready,
  output logic [CH_W+COARSE_W+FINE_W-1:0]   out_data,
  output logic                              busy,
  output logic [NCH-1:0]                    overflow,
  input  logic                              clr_ovf
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  state_t              state, state_nxt;
  logic [COARSE_W-1:0] coarse;
  logic [NCH-1:0]      pending, capture, lost, grant_vec;
  logic [FINE_W-1:0]   fine_q [NCH];
  logic [COARSE_W-1:0] ts_q   [NCH];
  logic [CH_W-1:0]     rr_ptr, grant_idx, cand;
  logic                grant_any, grant, slot_free;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (enable) state_nxt = RUN;
      RUN:     if (!enable) state_nxt = DRAIN;
      DRAIN:   if (pending == '0 && (!out_valid || out_ready)) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign busy = (state != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)              coarse <= '0;
    else if (state != IDLE)  coarse <= coarse + 1'b1;
    else if (enable)         coarse <= '0;
  end

  // Round-robin search over the registered pending set starting at rr_ptr.
  always_comb begin
    grant_any = 1'b0;
    grant_idx = '0;
    cand      = '0;
    for (int unsigned k = 0; k < NCH; k++) begin
      cand = CH_W'((32'(rr_ptr) + k) % NCH);
      if (!grant_any && pending[cand]) begin
        grant_any = 1'b1;
        grant_idx = cand;
      end
    end
  end

  assign slot_free = !out_valid || out_ready;
  assign grant     = slot_free && grant_any && (state != IDLE);

  always_comb begin
    grant_vec = '0;
    if (grant) grant_vec[grant_idx] = 1'b1;
  end

  // A channel being granted this cycle frees its slot for a same-cycle hit.
  assign capture = (state == RUN) ? (hit_valid & (~pending | grant_vec)) : '0;
  assign lost    = (state == RUN) ? (hit_valid & pending & ~grant_vec)   : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending <= '0;
      for (int unsigned i = 0; i < NCH; i++) begin
        fine_q[i] <= '0;
        ts_q[i]   <= '0;
      end
    end else begin
      pending <= (pending & ~grant_vec) | capture;
      for (int unsigned i = 0; i < NCH; i++) begin
        if (capture[i]) begin
          fine_q[i] <= hit_fine[i*FINE_W +: FINE_W];
          ts_q[i]   <= coarse;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       overflow <= '0;
    else if (clr_ovf) overflow <= lost;
    else              overflow <= overflow | lost;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      rr_ptr    <= '0;
    end else if (grant) begin
      out_valid <= 1'b1;
      out_data  <= {grant_idx, ts_q[grant_idx], fine_q[grant_idx]};
      rr_ptr    <= (grant_idx == CH_W'(NCH-1)) ? '0 : grant_idx + 1'b1;
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_tdc_hit_readout_arbiter.sv
// Bench for tdc_hit_readout_arbiter: table of hit bursts with hand-derived
// grant orders, plus sequences for stall, overflow, wrap, drain and reset.
module tb_tdc_hit_readout_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        enable;
  logic [7:0]  hit_valid;
  logic [31:0] hit_fine;
  logic        out_valid;
  logic        out_ready;
  logic [22:0] out_data;
  logic        busy;
  logic [7:0]  overflow;
  logic        clr_ovf;

  tdc_hit_readout_arbiter #(.NCH(8), .CH_W(3), .FINE_W(4), .COARSE_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .hit_valid(hit_valid),
    .hit_fine(hit_fine), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .busy(busy), .overflow(overflow), .clr_ovf(clr_ovf)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int unsigned n_vec = 0, n_err = 0;
  int unsigned pop_cnt = 0, last_pop_cyc = 0, c_en = 0;
  logic [22:0] exp_q[$];
  logic [22:0] mon_w;

  // Scoreboard: every accepted word must match the head of the queue.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && out_valid === 1'b1 && out_ready === 1'b1) begin
      n_vec++;
      pop_cnt++;
      last_pop_cyc = cyc;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL unexpected_word got=%h want=none", out_data);
      end else begin
        mon_w = exp_q.pop_front();
        if (out_data !== mon_w) begin
          n_err++;
          $display("FAIL word got=%h want=%h", out_data, mon_w);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    n_vec++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s got=%h want=%h", name, got, want);
    end
  endtask

  function automatic logic [22:0] word(input logic [2:0] ch, input logic [15:0] ts,
                                       input logic [31:0] fine);
    logic [31:0] f;
    f = fine;
    return {ch, ts, f[ch*4 +: 4]};
  endfunction

  task automatic drive_hits(input logic [7:0] mask, input logic [31:0] fine,
                            output logic [15:0] ts, output int unsigned c);
    hit_valid = mask;
    hit_fine  = fine;
    ts = 16'(cyc - c_en);
    c  = cyc;
    tick();
    hit_valid = '0;
  endtask

  task automatic wait_drain(input string name);
    int unsigned t;
    t = 0;
    while (exp_q.size() != 0 && t < 200) begin
      tick();
      t++;
    end
    if (exp_q.size() != 0) begin
      n_vec++;
      n_err++;
      $display("FAIL %s_timeout words_left=%0d want=0", name, exp_q.size());
      exp_q.delete();
    end
    repeat (3) tick();
  endtask

  typedef struct {
    logic [7:0]  hits;
    logic [31:0] fine;
    int unsigned n_out;
    logic [31:0] order;   // nibble k = channel of the k-th emitted word
  } vec_t;

  vec_t        tbl [6];
  logic [15:0] ts, ts2;
  int unsigned c_hit;
  logic [22:0] w1;
  logic [2:0]  ch;
  logic [31:0] f;

  initial begin
    // rr_ptr is 3 on entry (after the ch2 word of the first sequence)
    tbl[0] = '{hits: 8'h80, fine: 32'h1234_5678, n_out: 1, order: 32'h0000_0007};
    tbl[1] = '{hits: 8'h89, fine: 32'h9ABC_DEF0, n_out: 3, order: 32'h0000_0730};
    tbl[2] = '{hits: 8'h09, fine: 32'h0F1E_2D3C, n_out: 2, order: 32'h0000_0030};
    tbl[3] = '{hits: 8'h22, fine: 32'hA5A5_5A5A, n_out: 2, order: 32'h0000_0015};
    tbl[4] = '{hits: 8'hFF, fine: 32'hFEDC_BA98, n_out: 8, order: 32'h1076_5432};
    tbl[5] = '{hits: 8'h40, fine: 32'h1357_9BDF, n_out: 1, order: 32'h0000_0006};

    rst_n = 1'b0; enable = 1'b0; hit_valid = '0; hit_fine = '0;
    out_ready = 1'b1; clr_ovf = 1'b0;
    repeat (2) tick();
    check("rst_out_valid", 32'(out_valid), 0);
    check("rst_out_data", 32'(out_data), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_overflow", 32'(overflow), 0);
    rst_n = 1'b1;
    repeat (2) tick();
    check("idle_busy", 32'(busy), 0);

    // Single hit on ch2 at coarse 5
    enable = 1'b1;
    tick();
    c_en = cyc;
    check("run_busy", 32'(busy), 1);
    repeat (5) tick();
    pop_cnt = 0;
    drive_hits(8'h04, 32'h0000_0A00, ts, c_hit);
    exp_q.push_back(word(3'd2, 16'd5, 32'h0000_0A00));
    wait_drain("t1");
    check("t1_latency", last_pop_cyc - c_hit, 2);
    check("t1_words", pop_cnt, 1);

    for (int v = 0; v < 6; v++) begin
      drive_hits(tbl[v].hits, tbl[v].fine, ts, c_hit);
      for (int k = 0; k < int'(tbl[v].n_out); k++) begin
        f  = tbl[v].order;
        ch = f[k*4 +: 3];
        exp_q.push_back(word(ch, ts, tbl[v].fine));
      end
      wait_drain("tbl");
      check("tbl_last_word_cycle", last_pop_cyc - c_hit, tbl[v].n_out + 1);
    end

    // Stall: first ch1 word held, second pending, third and fourth lost
    out_ready = 1'b0;
    drive_hits(8'h02, 32'h0000_0030, ts, c_hit);
    w1 = word(3'd1, ts, 32'h0000_0030);
    exp_q.push_back(w1);
    tick();
    drive_hits(8'h02, 32'h0000_0090, ts2, c_hit);
    exp_q.push_back(word(3'd1, ts2, 32'h0000_0090));
    check("t3_valid_held", 32'(out_valid), 1);
    check("t3_data_held", 32'(out_data), 32'(w1));
    check("t3_no_ovf_yet", 32'(overflow), 0);
    tick();
    drive_hits(8'h02, 32'h0000_00C0, ts, c_hit);
    check("t3_ovf_set", 32'(overflow), 32'h02);
    clr_ovf = 1'b1;
    drive_hits(8'h02, 32'h0000_00D0, ts, c_hit);
    clr_ovf = 1'b0;
    check("t3_ovf_set_wins", 32'(overflow), 32'h02);
    clr_ovf = 1'b1;
    tick();
    clr_ovf = 1'b0;
    check("t3_ovf_cleared", 32'(overflow), 0);
    check("t3_data_still_held", 32'(out_data), 32'(w1));
    out_ready = 1'b1;
    wait_drain("t3");

    // Coarse wrap: hits at 0xFFFF and the following cycle
    for (int unsigned t = 0; t < 70000 && 16'(cyc - c_en) != 16'hFFFF; t++) tick();
    check("t4_reach_ffff", 32'(16'(cyc - c_en)), 32'h0000_FFFF);
    drive_hits(8'h10, 32'h0007_0000, ts, c_hit);
    exp_q.push_back(word(3'd4, 16'hFFFF, 32'h0007_0000));
    drive_hits(8'h20, 32'h00E0_0000, ts, c_hit);
    exp_q.push_back(word(3'd5, 16'h0000, 32'h00E0_0000));
    wait_drain("t4");

    // Drain with two words outstanding; hits during DRAIN are ignored
    out_ready = 1'b0;
    drive_hits(8'h44, 32'h0500_0300, ts, c_hit);
    exp_q.push_back(word(3'd6, ts, 32'h0500_0300));
    exp_q.push_back(word(3'd2, ts, 32'h0500_0300));
    enable = 1'b0;
    tick();
    check("t5_drain_busy", 32'(busy), 1);
    drive_hits(8'h05, 32'h0000_0F0F, ts, c_hit);
    repeat (2) tick();
    check("t5_drain_ovf", 32'(overflow), 0);
    check("t5_drain_busy_hold", 32'(busy), 1);
    out_ready = 1'b1;
    wait_drain("t5");
    check("t5_idle_busy", 32'(busy), 0);

    // Asynchronous reset with a word in flight and a hit pending
    enable = 1'b1;
    tick();
    out_ready = 1'b0;
    drive_hits(8'h28, 32'h0060_4000, ts, c_hit);
    drive_hits(8'h20, 32'h0010_0000, ts, c_hit);
    check("t6_pre_valid", 32'(out_valid), 1);
    check("t6_pre_ovf", 32'(overflow), 32'h20);
    #2;
    rst_n = 1'b0;
    #1;
    check("t6_async_valid", 32'(out_valid), 0);
    check("t6_async_ovf", 32'(overflow), 0);
    check("t6_async_busy", 32'(busy), 0);
    tick();
    rst_n = 1'b1;
    tick();
    c_en = cyc;
    out_ready = 1'b1;
    drive_hits(8'h02, 32'h0000_00B0, ts, c_hit);
    exp_q.push_back(word(3'd1, 16'h0000, 32'h0000_00B0));
    wait_drain("t6");
    check("t6_latency", last_pop_cyc - c_hit, 2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
